// File: rtl/reorder_buffer_if.sv
// ============================================================================
// Module      : reorder_buffer_if
// Description : Dispatch, completion and retire bundle of the reorder buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reorder_buffer_if #(
    parameter int PREG_W = 7,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
);
    logic [1:0]                   i_alloc_valid;
    logic [1:0][IDX_W-1:0]        i_alloc_rob_num;
    logic [1:0][PREG_W-1:0]       i_alloc_dst;
    logic [1:0][PREG_W-1:0]       i_alloc_old_dst;
    logic [1:0]                   i_alloc_regwrite;
    logic [1:0]                   i_alloc_memwrite;

    logic [2:0]                   i_cmp_valid;
    logic [2:0][IDX_W-1:0]        i_cmp_rob_num;
    logic [2:0][DATA_W-1:0]       i_cmp_data;

    logic                         o_stall;
    logic [IDX_W:0]               o_count;
    logic [1:0]                   o_retire_valid;
    logic [1:0][PREG_W-1:0]       o_retire_dst;
    logic [1:0][PREG_W-1:0]       o_retire_old_dst;
    logic [1:0][DATA_W-1:0]       o_retire_data;
    logic [1:0]                   o_retire_regwrite;
    logic [1:0]                   o_retire_memwrite;
    logic                         o_seq_error;

    modport master (
        output i_alloc_valid, i_alloc_rob_num, i_alloc_dst, i_alloc_old_dst,
               i_alloc_regwrite, i_alloc_memwrite,
               i_cmp_valid, i_cmp_rob_num, i_cmp_data,
        input  o_stall, o_count, o_retire_valid, o_retire_dst, o_retire_old_dst,
               o_retire_data, o_retire_regwrite, o_retire_memwrite, o_seq_error
    );

    modport slave (
        input  i_alloc_valid, i_alloc_rob_num, i_alloc_dst, i_alloc_old_dst,
               i_alloc_regwrite, i_alloc_memwrite,
               i_cmp_valid, i_cmp_rob_num, i_cmp_data,
        output o_stall, o_count, o_retire_valid, o_retire_dst, o_retire_old_dst,
               o_retire_data, o_retire_regwrite, o_retire_memwrite, o_seq_error
    );
endinterface

`default_nettype wire

// File: rtl/reorder_buffer.sv
// ============================================================================
// Module      : reorder_buffer
// Description : In-order reorder buffer, two-wide allocate, three completion
//               ports, in-order retire. ROB_DUAL_RETIRE_EN enables 2-wide retire.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = 7,
    parameter int DATA_W = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    reorder_buffer_if.slave rob_if
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]       valid_q, valid_d, complete_q, complete_d;
    logic [PREG_W-1:0]      dst_q  [DEPTH];
    logic [PREG_W-1:0]      dst_d  [DEPTH];
    logic [PREG_W-1:0]      old_q  [DEPTH];
    logic [PREG_W-1:0]      old_d  [DEPTH];
    logic [DATA_W-1:0]      data_q [DEPTH];
    logic [DATA_W-1:0]      data_d [DEPTH];
    logic [DEPTH-1:0]       rw_q, rw_d, mw_q, mw_d;

    logic [IDX_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   seq_err_q, seq_err_d;

    logic [1:0]             ret_valid_q, ret_valid_d;
    logic [1:0][PREG_W-1:0] ret_dst_q, ret_dst_d, ret_old_q, ret_old_d;
    logic [1:0][DATA_W-1:0] ret_data_q, ret_data_d;
    logic [1:0]             ret_rw_q, ret_rw_d, ret_mw_q, ret_mw_d;

    logic                   w_ret0, w_ret1;
    logic [1:0]             w_nret, w_nacc;
    logic [CNT_W-1:0]       w_free;
    logic [IDX_W-1:0]       w_idx;
`ifdef ROB_DUAL_RETIRE_EN
    logic [IDX_W-1:0]       w_head1;
    assign w_head1 = head_q + IDX_W'(1);
`endif

    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        dst_d      = dst_q;
        old_d      = old_q;
        data_d     = data_q;
        rw_d       = rw_q;
        mw_d       = mw_q;
        seq_err_d  = seq_err_q;
        ret_valid_d = '0;
        ret_dst_d   = '0;
        ret_old_d   = '0;
        ret_data_d  = '0;
        ret_rw_d    = '0;
        ret_mw_d    = '0;
        w_free = CNT_W'(DEPTH) - count_q;
        w_nacc = '0;
        w_idx  = tail_q;

        // Retire decisions look only at pre-edge state
        w_ret0 = valid_q[head_q] & complete_q[head_q];
`ifdef ROB_DUAL_RETIRE_EN
        w_ret1 = w_ret0 & valid_q[w_head1] & complete_q[w_head1];
`else
        w_ret1 = 1'b0;
`endif

        for (int p = 0; p < 3; p++) begin
            if (rob_if.i_cmp_valid[p]) begin
                for (int r = 0; r < p; r++) begin
                    if (rob_if.i_cmp_valid[r] &&
                        rob_if.i_cmp_rob_num[r] == rob_if.i_cmp_rob_num[p])
                        seq_err_d = 1'b1;
                end
                if (valid_q[rob_if.i_cmp_rob_num[p]]) begin
                    complete_d[rob_if.i_cmp_rob_num[p]] = 1'b1;
                    data_d[rob_if.i_cmp_rob_num[p]]     = rob_if.i_cmp_data[p];
                end else begin
                    seq_err_d = 1'b1;
                end
            end
        end

        if (w_ret0) begin
            ret_valid_d[0] = 1'b1;
            ret_dst_d[0]   = dst_q[head_q];
            ret_old_d[0]   = old_q[head_q];
            ret_data_d[0]  = data_q[head_q];
            ret_rw_d[0]    = rw_q[head_q];
            ret_mw_d[0]    = mw_q[head_q];
            valid_d[head_q]    = 1'b0;
            complete_d[head_q] = 1'b0;
        end
`ifdef ROB_DUAL_RETIRE_EN
        if (w_ret1) begin
            ret_valid_d[1] = 1'b1;
            ret_dst_d[1]   = dst_q[w_head1];
            ret_old_d[1]   = old_q[w_head1];
            ret_data_d[1]  = data_q[w_head1];
            ret_rw_d[1]    = rw_q[w_head1];
            ret_mw_d[1]    = mw_q[w_head1];
            valid_d[w_head1]    = 1'b0;
            complete_d[w_head1] = 1'b0;
        end
`endif

        // Accepted slots pack densely from tail; excess beyond free space is dropped
        for (int s = 0; s < 2; s++) begin
            if (rob_if.i_alloc_valid[s]) begin
                if (CNT_W'(w_nacc) < w_free) begin
                    w_idx = tail_q + IDX_W'(w_nacc);
                    if (rob_if.i_alloc_rob_num[s] != w_idx)
                        seq_err_d = 1'b1;
                    valid_d[w_idx]    = 1'b1;
                    complete_d[w_idx] = 1'b0;
                    data_d[w_idx]     = '0;
                    dst_d[w_idx]      = rob_if.i_alloc_dst[s];
                    old_d[w_idx]      = rob_if.i_alloc_old_dst[s];
                    rw_d[w_idx]       = rob_if.i_alloc_regwrite[s];
                    mw_d[w_idx]       = rob_if.i_alloc_memwrite[s];
                    w_nacc = w_nacc + 2'd1;
                end else begin
                    seq_err_d = 1'b1;
                end
            end
        end

        w_nret  = {1'b0, w_ret0} + {1'b0, w_ret1};
        head_d  = head_q + IDX_W'(w_nret);
        tail_d  = tail_q + IDX_W'(w_nacc);
        count_d = count_q + CNT_W'(w_nacc) - CNT_W'(w_nret);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q     <= '0;
            complete_q  <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            seq_err_q   <= 1'b0;
            ret_valid_q <= '0;
            ret_dst_q   <= '0;
            ret_old_q   <= '0;
            ret_data_q  <= '0;
            ret_rw_q    <= '0;
            ret_mw_q    <= '0;
        end else begin
            valid_q     <= valid_d;
            complete_q  <= complete_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            seq_err_q   <= seq_err_d;
            ret_valid_q <= ret_valid_d;
            ret_dst_q   <= ret_dst_d;
            ret_old_q   <= ret_old_d;
            ret_data_q  <= ret_data_d;
            ret_rw_q    <= ret_rw_d;
            ret_mw_q    <= ret_mw_d;
        end
    end

    // Payload is qualified by valid_q, so it needs no reset
    always_ff @(posedge i_clk) begin
        dst_q  <= dst_d;
        old_q  <= old_d;
        data_q <= data_d;
        rw_q   <= rw_d;
        mw_q   <= mw_d;
    end

    assign rob_if.o_stall           = (count_q > CNT_W'(DEPTH - 2));
    assign rob_if.o_count           = count_q;
    assign rob_if.o_seq_error       = seq_err_q;
    assign rob_if.o_retire_valid    = ret_valid_q;
    assign rob_if.o_retire_dst      = ret_dst_q;
    assign rob_if.o_retire_old_dst  = ret_old_q;
    assign rob_if.o_retire_data     = ret_data_q;
    assign rob_if.o_retire_regwrite = ret_rw_q;
    assign rob_if.o_retire_memwrite = ret_mw_q;

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reorder_buffer;
    localparam int DEPTH  = 16;
    localparam int PREG_W = 7;
    localparam int DATA_W = 32;
`ifdef ROB_DUAL_RETIRE_EN
    localparam int RET_W = 2;
`else
    localparam int RET_W = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reorder_buffer_if #(.PREG_W(PREG_W), .DATA_W(DATA_W), .IDX_W(4)) rif ();
    reorder_buffer #(.DEPTH(DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .rob_if (rif)
    );

    typedef struct {
        int           rob;
        logic [6:0]   dst;
        logic [6:0]   old;
        bit           done;
        logic [31:0]  data;
        bit           rw;
        bit           mw;
    } ent_t;

    ent_t              mq[$];
    int                m_ptr;
    bit                m_err;
    logic [1:0]        e_rv, e_rw, e_mw;
    logic [1:0][6:0]   e_rd, e_ro;
    logic [1:0][31:0]  e_data;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [104:0] dut_vec();
        return {rif.o_stall, rif.o_count, rif.o_seq_error, rif.o_retire_valid,
                rif.o_retire_dst, rif.o_retire_old_dst, rif.o_retire_data,
                rif.o_retire_regwrite, rif.o_retire_memwrite};
    endfunction

    function automatic logic [104:0] model_vec();
        return {(mq.size() >= DEPTH - 1), 5'(mq.size()), m_err, e_rv,
                e_rd, e_ro, e_data, e_rw, e_mw};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ptr = 0; m_err = 0;
        e_rv = '0; e_rw = '0; e_mw = '0; e_rd = '0; e_ro = '0; e_data = '0;
    endtask

    // One clock edge of the ROB: retire from the oldest completed rows,
    // record completions, then append accepted allocations.
    task automatic model_step();
        int pre  = mq.size();
        int nret = 0;
        int acc  = 0;
        while (nret < RET_W && nret < mq.size() && mq[nret].done) nret++;
        e_rv = '0; e_rw = '0; e_mw = '0; e_rd = '0; e_ro = '0; e_data = '0;
        for (int k = 0; k < nret; k++) begin
            e_rv[k] = 1'b1; e_rd[k] = mq[k].dst; e_ro[k] = mq[k].old;
            e_data[k] = mq[k].data; e_rw[k] = mq[k].rw; e_mw[k] = mq[k].mw;
        end
        for (int p = 0; p < 3; p++) begin
            if (rif.i_cmp_valid[p]) begin
                bit found = 0;
                for (int r = 0; r < p; r++)
                    if (rif.i_cmp_valid[r] && rif.i_cmp_rob_num[r] == rif.i_cmp_rob_num[p]) m_err = 1;
                foreach (mq[i]) begin
                    if (mq[i].rob == int'(rif.i_cmp_rob_num[p])) begin
                        mq[i].done = 1; mq[i].data = rif.i_cmp_data[p]; found = 1;
                    end
                end
                if (!found) m_err = 1;
            end
        end
        for (int k = 0; k < nret; k++) void'(mq.pop_front());
        for (int s = 0; s < 2; s++) begin
            if (rif.i_alloc_valid[s]) begin
                if (acc < DEPTH - pre) begin
                    ent_t e;
                    if (int'(rif.i_alloc_rob_num[s]) != m_ptr % DEPTH) m_err = 1;
                    e.rob = m_ptr % DEPTH; e.dst = rif.i_alloc_dst[s]; e.old = rif.i_alloc_old_dst[s];
                    e.done = 0; e.data = '0; e.rw = rif.i_alloc_regwrite[s]; e.mw = rif.i_alloc_memwrite[s];
                    mq.push_back(e);
                    m_ptr++; acc++;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic idle();
        rif.i_alloc_valid = '0; rif.i_alloc_rob_num = '0; rif.i_alloc_dst = '0;
        rif.i_alloc_old_dst = '0; rif.i_alloc_regwrite = '0; rif.i_alloc_memwrite = '0;
        rif.i_cmp_valid = '0; rif.i_cmp_rob_num = '0; rif.i_cmp_data = '0;
    endtask

    task automatic set_alloc(input int s, input logic [3:0] rob, input logic [6:0] dst,
                             input logic [6:0] old, input bit rw, input bit mw);
        rif.i_alloc_valid[s] = 1'b1; rif.i_alloc_rob_num[s] = rob;
        rif.i_alloc_dst[s] = dst; rif.i_alloc_old_dst[s] = old;
        rif.i_alloc_regwrite[s] = rw; rif.i_alloc_memwrite[s] = mw;
    endtask

    task automatic set_cmp(input int p, input logic [3:0] rob, input logic [31:0] data);
        rif.i_cmp_valid[p] = 1'b1; rif.i_cmp_rob_num[p] = rob; rif.i_cmp_data[p] = data;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic do_reset();
        idle();
        #2 rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (dut_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", dut_vec());
        else n_pass++;
        tick();
        n_chk++;
        if (dut_vec() !== model_vec()) $display("FAIL reset_idle: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        set_alloc(0, 4'd0, 7'd5, 7'd3, 1, 0);
        set_alloc(1, 4'd1, 7'd6, 7'd4, 1, 0);
        tick(); idle();
        n_chk++;
        if (rif.o_count !== 5'd2 || dut_vec() !== model_vec())
            $display("FAIL basic_alloc: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
        set_cmp(0, 4'd1, 32'hBEEF);
        tick(); idle();
        tick();
        n_chk++;
        if (rif.o_retire_valid !== 2'b00 || dut_vec() !== model_vec())
            $display("FAIL basic_no_retire: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
        set_cmp(2, 4'd0, 32'h1234);
        tick(); idle();
        tick();
`ifdef ROB_DUAL_RETIRE_EN
        n_chk++;
        if ({rif.o_retire_valid, rif.o_retire_dst[0], rif.o_retire_old_dst[0], rif.o_retire_data[0],
             rif.o_retire_dst[1], rif.o_retire_old_dst[1], rif.o_retire_data[1], rif.o_count} !==
            {2'b11, 7'd5, 7'd3, 32'h1234, 7'd6, 7'd4, 32'hBEEF, 5'd0})
            $display("FAIL basic_dual_retire: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
`else
        n_chk++;
        if ({rif.o_retire_valid, rif.o_retire_dst[0], rif.o_retire_old_dst[0], rif.o_retire_data[0], rif.o_count} !==
            {2'b01, 7'd5, 7'd3, 32'h1234, 5'd1})
            $display("FAIL basic_retire0: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
        tick();
        n_chk++;
        if ({rif.o_retire_valid, rif.o_retire_dst[0], rif.o_retire_old_dst[0], rif.o_retire_data[0], rif.o_count} !==
            {2'b01, 7'd6, 7'd4, 32'hBEEF, 5'd0})
            $display("FAIL basic_retire1: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
`endif
        n_chk++;
        if (dut_vec() !== model_vec()) $display("FAIL basic_model: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_fill();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            set_alloc(0, 4'(2*c), 7'(2*c+10), 7'(c), 1, 0);
            set_alloc(1, 4'(2*c+1), 7'(2*c+11), 7'(c+40), 0, 1);
            tick(); idle();
        end
        n_chk++;
        if ({rif.o_count, rif.o_stall} !== {5'd14, 1'b0} || dut_vec() !== model_vec())
            $display("FAIL fill_14: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
        set_alloc(0, 4'd14, 7'd24, 7'd1, 1, 0);
        tick(); idle();
        n_chk++;
        if ({rif.o_count, rif.o_stall} !== {5'd15, 1'b1} || dut_vec() !== model_vec())
            $display("FAIL fill_15_stall: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
        set_alloc(1, 4'd15, 7'd25, 7'd2, 1, 0);
        tick(); idle();
        n_chk++;
        if ({rif.o_count, rif.o_stall, rif.o_seq_error} !== {5'd16, 1'b1, 1'b0} || dut_vec() !== model_vec())
            $display("FAIL fill_16: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
        set_alloc(0, 4'd0, 7'd26, 7'd3, 1, 0);
        tick(); idle();
        n_chk++;
        if ({rif.o_count, rif.o_seq_error} !== {5'd16, 1'b1} || dut_vec() !== model_vec())
            $display("FAIL fill_overflow: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_wraparound();
        logic [6:0] dq[$];
        int         n_alloc = 0;
        int         n_ret   = 0;
        do_reset();
        for (int cyc = 0; cyc < 340; cyc++) begin
            int cand[$];
            idle();
            if (cyc < 300 && mq.size() <= DEPTH - 2) begin
                logic [1:0] m = 2'($urandom_range(0, 3));
                int p = m_ptr;
                for (int s = 0; s < 2; s++) begin
                    if (m[s]) begin
                        logic [6:0] d = 7'($urandom);
                        set_alloc(s, 4'(p % DEPTH), d, 7'($urandom), 1'($urandom), 1'($urandom));
                        dq.push_back(d);
                        p++; n_alloc++;
                    end
                end
            end
            foreach (mq[i]) if (!mq[i].done) cand.push_back(i);
            for (int port = 0; port < 3; port++) begin
                if (cand.size() > 0 && (cyc >= 300 || $urandom_range(0, 2) != 0)) begin
                    int k = $urandom_range(0, cand.size() - 1);
                    set_cmp(port, 4'(mq[cand[k]].rob), $urandom);
                    cand.delete(k);
                end
            end
            tick();
            n_chk++;
            if (dut_vec() !== model_vec()) $display("FAIL wrap_cycle%0d: got %h want %h", cyc, dut_vec(), model_vec());
            else n_pass++;
            for (int k = 0; k < 2; k++) begin
                if (rif.o_retire_valid[k]) begin
                    n_ret++;
                    n_chk++;
                    if (dq.size() == 0) $display("FAIL wrap_order: got dst %h want none", rif.o_retire_dst[k]);
                    else if (rif.o_retire_dst[k] !== dq[0]) $display("FAIL wrap_order: got dst %h want %h", rif.o_retire_dst[k], dq[0]);
                    else n_pass++;
                    if (dq.size() != 0) void'(dq.pop_front());
                end
            end
        end
        idle();
        n_chk++;
        if (n_ret != n_alloc || n_alloc < 40 || {rif.o_count, rif.o_seq_error} !== 6'd0)
            $display("FAIL wrap_drain: got retired %0d count %0d err %0d want retired %0d count 0 err 0",
                     n_ret, rif.o_count, rif.o_seq_error, n_alloc);
        else n_pass++;
    endtask

    task automatic test_bad_cmp_and_async_reset();
        do_reset();
        set_cmp(1, 4'd7, 32'hDEAD);
        tick(); idle();
        n_chk++;
        if ({rif.o_seq_error, rif.o_count} !== {1'b1, 5'd0} || dut_vec() !== model_vec())
            $display("FAIL bad_cmp: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
        set_alloc(0, 4'd0, 7'd9, 7'd8, 1, 0);
        set_alloc(1, 4'd1, 7'd10, 7'd7, 1, 0);
        tick(); idle();
        set_cmp(0, 4'd0, 32'h55);
        tick(); idle();
        tick();
        n_chk++;
        if (dut_vec() !== model_vec()) $display("FAIL pre_reset: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (dut_vec() !== '0) $display("FAIL async_reset: got %h want 0", dut_vec());
        else n_pass++;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        n_chk++;
        if (dut_vec() !== model_vec()) $display("FAIL after_reset: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
    endtask

    task automatic test_retire_width();
        do_reset();
        set_alloc(0, 4'd0, 7'd20, 7'd30, 1, 1);
        set_alloc(1, 4'd1, 7'd21, 7'd31, 0, 0);
        tick(); idle();
        set_cmp(0, 4'd1, 32'hA1);
        set_cmp(1, 4'd0, 32'hA0);
        tick(); idle();
        tick();
`ifdef ROB_DUAL_RETIRE_EN
        n_chk++;
        if (rif.o_retire_valid !== 2'b11 || dut_vec() !== model_vec())
            $display("FAIL retire_width_dual: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
`else
        n_chk++;
        if ({rif.o_retire_valid, rif.o_retire_data[0]} !== {2'b01, 32'hA0} || dut_vec() !== model_vec())
            $display("FAIL retire_width_first: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
        tick();
        n_chk++;
        if ({rif.o_retire_valid, rif.o_retire_data[0]} !== {2'b01, 32'hA1} || dut_vec() !== model_vec())
            $display("FAIL retire_width_second: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
`endif
        tick();
        n_chk++;
        if (rif.o_retire_valid !== 2'b00 || dut_vec() !== model_vec())
            $display("FAIL retire_width_idle: got %h want %h", dut_vec(), model_vec());
        else n_pass++;
    endtask

    initial begin
        idle();
        model_reset();
        test_reset();
        test_basic();
        test_fill();
        test_wraparound();
        test_bad_cmp_and_async_reset();
        test_retire_width();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
